// File: rtl/score_display_pkg.sv
// Shared constants for the score display: FSM state codes, conversion length
// and the active-low {g,f,e,d,c,b,a} segment patterns.
package score_display_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOAD   = 2'd1;
    localparam state_t ST_SHIFT  = 2'd2;
    localparam state_t ST_COMMIT = 2'd3;

    // Saturated scores are below 2^14, so 14 shift steps cover every source bit.
    localparam int BCD_ITERS = 14;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

endpackage

// File: rtl/score_display_seg7_decode.sv
// BCD digit to active-low 7-segment pattern; codes 10-15 show nothing.
module seg7_decode
    import score_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // NOTE: default assignment first so no path through always_comb infers a latch.
    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/score_display.sv
// Binary score to saturated 4-digit BCD via sequential double-dabble, shown on
// a multiplexed common-anode 7-segment display with leading-zero blanking.
module score_display
    import score_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 25000,
    parameter int unsigned SAT_VALUE   = 9999
) (
    input  logic        vga_clk,
    input  logic        arst_n,
    input  logic [15:0] coin_cnt,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned    CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [15:0]    SAT16     = 16'(SAT_VALUE);
    localparam logic [3:0]     ITER_LAST = 4'(BCD_ITERS - 1);

    state_t        state_q, state_d;
    logic [15:0]   last_val_q, last_val_d;
    logic [15:0]   src_q, src_d;
    logic [15:0]   scratch_q, scratch_d;
    logic [3:0]    iter_q, iter_d;
    logic          ovf_pend_q, ovf_pend_d;
    logic [15:0]   digits_q, digits_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]    scan_idx_q, scan_idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic [15:0]   sat;
    logic [15:0]   adj;
    logic [3:0]    digit_sel;
    logic          blank;
    logic [6:0]    dec_seg;

    assign sat = (coin_cnt > SAT16) ? SAT16 : coin_cnt;

    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_val_d = last_val_q;
        src_d      = src_q;
        scratch_d  = scratch_q;
        iter_d     = iter_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        busy_d     = busy_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (coin_cnt != last_val_q) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                // The two always-zero top bits are skipped by pre-shifting.
                src_d      = sat << 2;
                ovf_pend_d = (coin_cnt > SAT16);
                last_val_d = coin_cnt;
                scratch_d  = '0;
                iter_d     = '0;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                scratch_d = {adj[14:0], src_q[15]};
                src_d     = {src_q[14:0], 1'b0};
                iter_d    = iter_q + 4'd1;
                if (iter_q == ITER_LAST) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                digits_d   = scratch_q;
                overflow_d = ovf_pend_q;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        refresh_cnt_d = refresh_cnt_q + 1'b1;
        scan_idx_d    = scan_idx_q;
        if (refresh_cnt_q == CNT_MAX) begin
            refresh_cnt_d = '0;
            scan_idx_d    = scan_idx_q + 2'd1;
        end
    end

    always_comb begin
        digit_sel = digits_q[{scan_idx_q, 2'b00} +: 4];
        case (scan_idx_q)
            2'd1:    blank = (digits_q[15:4]  == 12'd0);
            2'd2:    blank = (digits_q[15:8]  == 8'd0);
            2'd3:    blank = (digits_q[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
    end

    seg7_decode u_decode (
        .bcd (digit_sel),
        .seg (dec_seg)
    );

    assign seg_d = blank ? SEG_BLANK : dec_seg;
    assign an_d  = ~(4'b0001 << scan_idx_q);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= ST_IDLE;
            last_val_q    <= '0;
            src_q         <= '0;
            scratch_q     <= '0;
            iter_q        <= '0;
            ovf_pend_q    <= 1'b0;
            digits_q      <= '0;
            busy_q        <= 1'b0;
            overflow_q    <= 1'b0;
            refresh_cnt_q <= '0;
            scan_idx_q    <= '0;
            seg_q         <= SEG_BLANK;
            an_q          <= 4'hF;
        end else begin
            state_q       <= state_d;
            last_val_q    <= last_val_d;
            src_q         <= src_d;
            scratch_q     <= scratch_d;
            iter_q        <= iter_d;
            ovf_pend_q    <= ovf_pend_d;
            digits_q      <= digits_d;
            busy_q        <= busy_d;
            overflow_q    <= overflow_d;
            refresh_cnt_q <= refresh_cnt_d;
            scan_idx_q    <= scan_idx_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign dp       = 1'b1;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule
